// File: rtl/pwm_multi_ctr.sv
// Multi-channel PWM: one shared period counter, per-channel duty compare, shadowed period/duty
// registers applied only at a period boundary. Define PWM_CENTER_ALIGN_EN for center-aligned counting.
module pwm_multi_ctr #(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned CNT_W          = 13,
  parameter int unsigned DEFAULT_PERIOD = 4999
) (
  input  logic                    clk_in,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
`ifdef PWM_CENTER_ALIGN_EN
  input  logic                    center_mode,
`endif
  input  logic [CNT_W-1:0]        period_in,
  input  logic [NUM_CH*CNT_W-1:0] duty_in,
  output logic [NUM_CH-1:0]       pwm_out,
  output logic                    period_start,
  output logic                    load_done
);

  logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_step;
  logic [CNT_W-1:0]        per_act_q, per_act_d;
  logic [CNT_W-1:0]        duty_act_q [NUM_CH];
  logic [CNT_W-1:0]        duty_act_d [NUM_CH];
  logic [CNT_W-1:0]        sh_per_q, sh_per_d;
  logic [NUM_CH*CNT_W-1:0] sh_duty_q, sh_duty_d;
  logic                    pending_q, pending_d;
  logic [NUM_CH-1:0]       pwm_q, pwm_d;
  logic                    ps_q, ps_d;
  logic                    ld_q, ld_d;
  logic                    last_c, apply_c;

`ifdef PWM_CENTER_ALIGN_EN
  typedef enum logic {DIR_UP, DIR_DOWN} dir_e;
  dir_e dir_q, dir_d;
  logic mode_q, mode_d;
`endif

  always_comb begin
    // last_c marks the final cycle of a period: the counter returns to 0 on the next edge
    last_c   = (cnt_q == per_act_q);
    cnt_step = last_c ? '0 : cnt_q + 1'b1;
`ifdef PWM_CENTER_ALIGN_EN
    dir_d = dir_q;
    if (mode_q && (per_act_q != '0)) begin
      if (dir_q == DIR_UP) begin
        if (cnt_q < per_act_q) begin
          last_c   = 1'b0;
          cnt_step = cnt_q + 1'b1;
        end else begin
          last_c   = (per_act_q == CNT_W'(1));
          cnt_step = cnt_q - 1'b1;
          dir_d    = DIR_DOWN;
        end
      end else begin
        last_c   = (cnt_q <= CNT_W'(1));
        cnt_step = last_c ? '0 : cnt_q - 1'b1;
      end
      if (last_c) dir_d = DIR_UP;
    end
    if (!en) dir_d = DIR_UP;
    mode_d = (!en || last_c) ? center_mode : mode_q;
`endif

    // With en low there is no period to protect, so a pending shadow applies immediately
    apply_c    = pending_q && (!en || last_c);
    cnt_d      = en ? cnt_step : '0;
    ps_d       = en && (cnt_q == '0);
    ld_d       = apply_c;
    per_act_d  = per_act_q;
    duty_act_d = duty_act_q;
    sh_per_d   = sh_per_q;
    sh_duty_d  = sh_duty_q;
    pending_d  = pending_q;
    pwm_d      = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      pwm_d[i] = en && (cnt_q < duty_act_q[i]);
    end

    if (apply_c) begin
      per_act_d = sh_per_q;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        duty_act_d[i] = sh_duty_q[i*CNT_W +: CNT_W];
      end
      pending_d = 1'b0;
    end
    // A load on the apply cycle refills the shadow after the old contents were consumed
    if (load) begin
      sh_per_d  = period_in;
      sh_duty_d = duty_in;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt_q      <= '0;
      per_act_q  <= CNT_W'(DEFAULT_PERIOD);
      duty_act_q <= '{default: '0};
      sh_per_q   <= '0;
      sh_duty_q  <= '0;
      pending_q  <= 1'b0;
      pwm_q      <= '0;
      ps_q       <= 1'b0;
      ld_q       <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
      dir_q      <= DIR_UP;
      mode_q     <= 1'b0;
`endif
    end else begin
      cnt_q      <= cnt_d;
      per_act_q  <= per_act_d;
      duty_act_q <= duty_act_d;
      sh_per_q   <= sh_per_d;
      sh_duty_q  <= sh_duty_d;
      pending_q  <= pending_d;
      pwm_q      <= pwm_d;
      ps_q       <= ps_d;
      ld_q       <= ld_d;
`ifdef PWM_CENTER_ALIGN_EN
      dir_q      <= dir_d;
      mode_q     <= mode_d;
`endif
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = ps_q;
  assign load_done    = ld_q;

endmodule

// File: tb/tb_pwm_multi_ctr.sv
// Self-checking bench for pwm_multi_ctr (edge-aligned build): directed scenarios plus random
// stimulus compared cycle by cycle against a period/phase reference model.
`timescale 1ns/1ps
module tb_pwm_multi_ctr;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 13;
  localparam int DEF    = 4999;

  logic                    clk_in = 1'b0;
  logic                    rst = 1'b1, en = 1'b0, load = 1'b0;
  logic [CNT_W-1:0]        period_in = '0;
  logic [NUM_CH*CNT_W-1:0] duty_in = '0;
  logic [NUM_CH-1:0]       pwm_out;
  logic                    period_start, load_done;

  int errors = 0;
  int checks = 0;

  // Reference model: phase within the current period, active and shadow settings, predicted outputs
  int              m_phase = 0, m_per = DEF, s_per = 0;
  int              m_duty [NUM_CH];
  int              s_duty [NUM_CH];
  bit              m_pend = 0;
  logic [NUM_CH-1:0] e_pwm = '0;
  logic            e_ps = 1'b0, e_ld = 1'b0;

  pwm_multi_ctr #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_PERIOD(DEF)) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .en          (en),
    .load        (load),
`ifdef PWM_CENTER_ALIGN_EN
    .center_mode (1'b0),
`endif
    .period_in   (period_in),
    .duty_in     (duty_in),
    .pwm_out     (pwm_out),
    .period_start(period_start),
    .load_done   (load_done)
  );

  always #100 clk_in = ~clk_in;

  task automatic step();
    bit last;
    @(posedge clk_in);
    if (rst) begin
      m_phase = 0; m_per = DEF; s_per = 0; m_pend = 0;
      for (int i = 0; i < NUM_CH; i++) begin m_duty[i] = 0; s_duty[i] = 0; end
      e_pwm = '0; e_ps = 1'b0; e_ld = 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) e_pwm[i] = en && (m_phase < m_duty[i]);
      e_ps    = en && (m_phase == 0);
      last    = !en || (m_phase == m_per);
      e_ld    = m_pend && last;
      m_phase = last ? 0 : m_phase + 1;
      if (e_ld) begin
        m_per = s_per;
        for (int i = 0; i < NUM_CH; i++) m_duty[i] = s_duty[i];
        m_pend = 0;
      end
      if (load) begin
        s_per = int'(period_in);
        for (int i = 0; i < NUM_CH; i++) s_duty[i] = int'(duty_in[i*CNT_W +: CNT_W]);
        m_pend = 1;
      end
    end
    #1;
  endtask

  function automatic logic [NUM_CH*CNT_W-1:0] pack(int d0, int d1, int d2, int d3);
    return {CNT_W'(d3), CNT_W'(d2), CNT_W'(d1), CNT_W'(d0)};
  endfunction

  task automatic do_load(int per, int d0, int d1, int d2, int d3);
    period_in = CNT_W'(per);
    duty_in   = pack(d0, d1, d2, d3);
    load      = 1'b1;
    step();
    load      = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0;
    step(); step();
    checks++; if (pwm_out !== '0) begin errors++; $display("FAIL reset_pwm: got %b expected 0000", pwm_out); end
    checks++; if (period_start !== 1'b0) begin errors++; $display("FAIL reset_ps: got %b expected 0", period_start); end
    checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL reset_ld: got %b expected 0", load_done); end
    rst = 1'b0;
  endtask

  task automatic test_default_period();
    int last = -1, n = 0, gap = -1, hi = 0;
    en = 1'b1;
    for (int c = 0; c < 5005; c++) begin
      step();
      if (pwm_out !== '0) hi++;
      if (period_start === 1'b1) begin
        if (last >= 0) gap = c - last;
        last = c; n++;
      end
    end
    checks++; if (n != 2) begin errors++; $display("FAIL default_ps_count: got %0d expected 2", n); end
    checks++; if (gap != 5000) begin errors++; $display("FAIL default_ps_gap: got %0d expected 5000", gap); end
    checks++; if (hi != 0) begin errors++; $display("FAIL default_pwm_low: got %0d high cycles expected 0", hi); end
  endtask

  task automatic test_load_apply();
    int w = 0, early = 0, ps_n = 0, ld_n = 0;
    int h [NUM_CH];
    for (int i = 0; i < NUM_CH; i++) h[i] = 0;
    do_load(9, 0, 3, 10, 12);
    while (load_done !== 1'b1 && w < 6000) begin
      step(); w++;
      if (pwm_out !== '0) early++;
    end
    checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL apply_timeout: load_done %b after %0d cycles expected 1", load_done, w); end
    checks++; if (early != 0) begin errors++; $display("FAIL apply_early: got %0d early high cycles expected 0", early); end
    for (int c = 0; c < 10; c++) begin
      step();
      if (c == 0) begin
        checks++; if (pwm_out !== 4'b1110) begin errors++; $display("FAIL apply_first: got %b expected 1110", pwm_out); end
      end
      for (int i = 0; i < NUM_CH; i++) h[i] += int'(pwm_out[i]);
      ps_n += int'(period_start);
      ld_n += int'(load_done);
    end
    checks++; if (h[0] != 0)  begin errors++; $display("FAIL apply_ch0: got %0d expected 0", h[0]); end
    checks++; if (h[1] != 3)  begin errors++; $display("FAIL apply_ch1: got %0d expected 3", h[1]); end
    checks++; if (h[2] != 10) begin errors++; $display("FAIL apply_ch2: got %0d expected 10", h[2]); end
    checks++; if (h[3] != 10) begin errors++; $display("FAIL apply_ch3: got %0d expected 10", h[3]); end
    checks++; if (ps_n != 1) begin errors++; $display("FAIL apply_ps: got %0d expected 1", ps_n); end
    checks++; if (ld_n != 0) begin errors++; $display("FAIL apply_ld_once: got %0d extra expected 0", ld_n); end
  endtask

  task automatic wait_ps(string tag);
    int w = 0;
    do begin step(); w++; end while (period_start !== 1'b1 && w < 30);
    checks++; if (period_start !== 1'b1) begin errors++; $display("FAIL %s_ps_timeout: got %b expected 1", tag, period_start); end
  endtask

  task automatic test_back_to_back();
    int ld_n = 0, h = 0, after = 0;
    wait_ps("b2b");
    do_load(9, 0, 2, 10, 12);
    step();
    do_load(9, 0, 7, 10, 12);
    for (int c = 0; c < 20; c++) begin
      step();
      if (after > 0 && after <= 10) h += int'(pwm_out[1]);
      if (after > 0) after++;
      if (load_done === 1'b1) begin ld_n++; if (after == 0) after = 1; end
    end
    checks++; if (ld_n != 1) begin errors++; $display("FAIL b2b_ld_count: got %0d expected 1", ld_n); end
    checks++; if (h != 7) begin errors++; $display("FAIL b2b_ch1_high: got %0d expected 7", h); end
  endtask

  task automatic test_load_on_wrap();
    int ld_n, ha = 0, hb = 0;
    wait_ps("wrap");
    do_load(9, 0, 5, 10, 12);
    for (int c = 0; c < 7; c++) step();
    do_load(9, 0, 1, 10, 12);
    ld_n = int'(load_done);
    for (int c = 1; c <= 20; c++) begin
      step();
      if (c <= 10) ha += int'(pwm_out[1]); else hb += int'(pwm_out[1]);
      ld_n += int'(load_done);
    end
    checks++; if (ld_n != 2) begin errors++; $display("FAIL wrap_ld_count: got %0d expected 2", ld_n); end
    checks++; if (ha != 5) begin errors++; $display("FAIL wrap_first_duty: got %0d expected 5", ha); end
    checks++; if (hb != 1) begin errors++; $display("FAIL wrap_second_duty: got %0d expected 1", hb); end
  endtask

  task automatic test_enable();
    int w = 0, gap = -1, h = 0;
    do_load(9, 0, 6, 10, 12);
    while (load_done !== 1'b1 && w < 30) begin step(); w++; end
    step(); step();
    checks++; if (pwm_out[1] !== 1'b1) begin errors++; $display("FAIL en_pre_high: got %b expected 1", pwm_out[1]); end
    en = 1'b0;
    step();
    checks++; if (pwm_out !== '0) begin errors++; $display("FAIL en_off_pwm: got %b expected 0000", pwm_out); end
    checks++; if (period_start !== 1'b0) begin errors++; $display("FAIL en_off_ps: got %b expected 0", period_start); end
    do_load(9, 0, 4, 10, 12);
    step();
    checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL en_off_apply: got %b expected 1", load_done); end
    step();
    checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL en_off_ld_pulse: got %b expected 0", load_done); end
    en = 1'b1;
    step();
    checks++; if (period_start !== 1'b1) begin errors++; $display("FAIL en_on_ps: got %b expected 1", period_start); end
    checks++; if (pwm_out !== 4'b1110) begin errors++; $display("FAIL en_on_pwm: got %b expected 1110", pwm_out); end
    h = int'(pwm_out[1]);
    for (int c = 1; c <= 30; c++) begin
      step();
      if (period_start === 1'b1) begin gap = c; break; end
      h += int'(pwm_out[1]);
    end
    checks++; if (gap != 10) begin errors++; $display("FAIL en_first_period: got %0d expected 10", gap); end
    checks++; if (h != 4) begin errors++; $display("FAIL en_first_duty: got %0d expected 4", h); end
  endtask

  task automatic test_reset_mid();
    int last = -1, gap = -1, hi = 0;
    step(); step();
    rst = 1'b1;
    step();
    checks++; if (pwm_out !== '0) begin errors++; $display("FAIL rstmid_pwm: got %b expected 0000", pwm_out); end
    checks++; if (period_start !== 1'b0) begin errors++; $display("FAIL rstmid_ps: got %b expected 0", period_start); end
    checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL rstmid_ld: got %b expected 0", load_done); end
    rst = 1'b0; en = 1'b1;
    for (int c = 0; c < 5005; c++) begin
      step();
      if (pwm_out !== '0) hi++;
      if (period_start === 1'b1) begin
        if (last >= 0) gap = c - last;
        last = c;
      end
    end
    checks++; if (gap != 5000) begin errors++; $display("FAIL rstmid_period: got %0d expected 5000", gap); end
    checks++; if (hi != 0) begin errors++; $display("FAIL rstmid_duty_cleared: got %0d high cycles expected 0", hi); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      rst       = ($urandom_range(0, 149) == 0);
      en        = ($urandom_range(0, 9) != 0);
      load      = ($urandom_range(0, 5) == 0);
      period_in = CNT_W'($urandom_range(0, 7));
      duty_in   = pack($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9));
      step();
      checks++; if (pwm_out !== e_pwm) begin errors++; $display("FAIL rand_pwm cyc %0d: got %b expected %b", c, pwm_out, e_pwm); end
      checks++; if (period_start !== e_ps) begin errors++; $display("FAIL rand_ps cyc %0d: got %b expected %b", c, period_start, e_ps); end
      checks++; if (load_done !== e_ld) begin errors++; $display("FAIL rand_ld cyc %0d: got %b expected %b", c, load_done, e_ld); end
    end
    rst = 1'b0; load = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NUM_CH; i++) begin m_duty[i] = 0; s_duty[i] = 0; end
    test_reset();
    test_default_period();
    test_load_apply();
    test_back_to_back();
    test_load_on_wrap();
    test_enable();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
